// File: rtl/seq_array_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock through a single
// subtract/restore row, with a start/busy/done handshake and registered results.
module seq_array_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   dvd, dvd_n;
    logic [WIDTH-1:0]   dvs, dvs_n;
    logic [WIDTH-1:0]   rem, rem_n;
    logic [WIDTH-1:0]   q_n, r_n;
    logic [WIDTH:0]     shifted, trial;
    logic               qbit, done_n, dz_n;

    // The working remainder is WIDTH+1 bits; its stored top bit is always zero
    // because a kept trial is smaller than the divisor, so only WIDTH bits are held.
    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        qbit    = ~trial[WIDTH];
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dvd_n   = dvd;
        dvs_n   = dvs;
        rem_n   = rem;
        q_n     = Q;
        r_n     = R;
        dz_n    = div_by_zero;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (B == '0) begin
                        q_n    = '1;
                        r_n    = A;
                        dz_n   = 1'b1;
                        done_n = 1'b1;
                    end else begin
                        dvd_n   = A;
                        dvs_n   = B;
                        rem_n   = '0;
                        cnt_n   = '0;
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                rem_n = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                dvd_n = {dvd[WIDTH-2:0], qbit};
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    q_n     = dvd_n;
                    r_n     = rem_n;
                    dz_n    = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            Q           <= '0;
            R           <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            Q           <= q_n;
            R           <= r_n;
            done        <= done_n;
            div_by_zero <= dz_n;
        end
    end

    // Working registers carry no reset; they are reloaded on every accepted start.
    always_ff @(posedge clk) begin
        dvd <= dvd_n;
        dvs <= dvs_n;
        rem <= rem_n;
    end

    assign busy = (state == CALC);

endmodule

// File: tb/tb_seq_array_divider.sv
// Bench for seq_array_divider: directed vector table, handshake corner cases and a
// random back-to-back run, all checked through an expected-result queue.
module tb_seq_array_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] a, b, q, r;
    logic         busy, done, dz;

    always #5 clk = ~clk;

    seq_array_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
        .Q(q), .R(r), .busy(busy), .done(done), .div_by_zero(dz)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t   sb[$];
    vec_t   tbl[10];
    vec_t   mon_e;
    int     total = 0, bad = 0, done_cnt = 0, acc_cnt = 0;
    logic [W-1:0] hold_q = '0, hold_r = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] aa, input logic [W-1:0] bb);
        vec_t v;
        v.a = aa;
        v.b = bb;
        if (bb == '0) begin
            v.q  = '1;
            v.r  = aa;
            v.dz = 1'b1;
        end else begin
            v.q  = aa / bb;
            v.r  = aa % bb;
            v.dz = 1'b0;
        end
        return v;
    endfunction

    // Result monitor: pops the scoreboard on done, and checks outputs hold during a run.
    always @(negedge clk) begin
        if (rst) begin
            hold_q = '0;
            hold_r = '0;
        end else if (done) begin
            done_cnt++;
            check("busy_with_done", 32'(busy), 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done with q=%0d r=%0d, expected no done", q, r);
            end else begin
                mon_e = sb.pop_front();
                check("q", 32'(q), 32'(mon_e.q));
                check("r", 32'(r), 32'(mon_e.r));
                check("div_by_zero", 32'(dz), 32'(mon_e.dz));
                if (!mon_e.dz)
                    check("q*b+r==a", 32'(q) * 32'(mon_e.b) + 32'(r), 32'(mon_e.a));
            end
            hold_q = q;
            hold_r = r;
        end else if (busy) begin
            check("q_hold", 32'(q), 32'(hold_q));
            check("r_hold", 32'(r), 32'(hold_r));
        end
    end

    task automatic wait_done(input int bound, output int k, output int busy_n);
        k = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
            if (busy) busy_n++;
        end while (!done && k < bound);
    endtask

    task automatic run(input vec_t v, input string name);
        int k, bn;
        sb.push_back(v);
        acc_cnt++;
        a = v.a;
        b = v.b;
        start = 1'b1;
        wait_done(W + 4, k, bn);
        check({name, "_done_seen"}, 32'(done), 32'd1);
        check({name, "_latency"}, 32'(k), (v.b == '0) ? 32'd1 : 32'(W + 1));
        check({name, "_busy_cycles"}, 32'(bn), (v.b == '0) ? 32'd0 : 32'(W));
    endtask

    initial begin
        int k, bn, seen, cyc, n;
        logic [W-1:0] aa, bb;

        tbl[0] = '{a: 200, b: 7,  q: 28,  r: 4,  dz: 0};
        tbl[1] = '{a: 255, b: 1,  q: 255, r: 0,  dz: 0};
        tbl[2] = '{a: 5,   b: 9,  q: 0,   r: 5,  dz: 0};
        tbl[3] = '{a: 0,   b: 3,  q: 0,   r: 0,  dz: 0};
        tbl[4] = '{a: 37,  b: 0,  q: 255, r: 37, dz: 1};
        tbl[5] = '{a: 37,  b: 5,  q: 7,   r: 2,  dz: 0};
        tbl[6] = '{a: 255, b: 255, q: 1,  r: 0,  dz: 0};
        tbl[7] = '{a: 254, b: 255, q: 0,  r: 254, dz: 0};
        tbl[8] = '{a: 0,   b: 0,  q: 255, r: 0,  dz: 1};
        tbl[9] = '{a: 128, b: 2,  q: 64,  r: 0,  dz: 0};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("reset_q", 32'(q), 32'd0);
        check("reset_r", 32'(r), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dz", 32'(dz), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Start pulsed mid-run must be ignored; start on the done cycle must be taken.
        sb.push_back('{a: 100, b: 10, q: 10, r: 0, dz: 0});
        acc_cnt++;
        a = 100;
        b = 10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 9;
        b = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        k = 4;
        while (!done && k < W + 6) begin
            @(negedge clk);
            k++;
        end
        check("ignored_start_latency", 32'(k), 32'(W + 1));
        sb.push_back('{a: 9, b: 2, q: 4, r: 1, dz: 0});
        acc_cnt++;
        a = 9;
        b = 2;
        start = 1'b1;
        wait_done(W + 4, k, bn);
        check("b2b_latency", 32'(k), 32'(W + 1));
        check("b2b_busy_cycles", 32'(bn), 32'(W));

        // Reset during iteration 4 aborts with no done pulse.
        a = 250;
        b = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_q", 32'(q), 32'd0);
        check("abort_r", 32'(r), 32'd0);
        check("abort_dz", 32'(dz), 32'd0);
        seen = 0;
        repeat (W + 2) begin
            if (done) seen++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run('{a: 250, b: 3, q: 83, r: 1, dz: 0}, "after_abort");

        // Random back-to-back traffic; input noise while busy must be ignored.
        cyc = 0;
        n = 0;
        while (n < 2000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (!busy) begin
                if ($urandom_range(0, 7) != 0) begin
                    aa = W'($urandom);
                    bb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
                    sb.push_back(model(aa, bb));
                    acc_cnt++;
                    n++;
                    a = aa;
                    b = bb;
                    start = 1'b1;
                end
            end else begin
                a = W'($urandom);
                b = W'($urandom);
                start = 1'($urandom_range(0, 1));
            end
        end
        check("random_ops_issued", 32'(n), 32'd2000);
        cyc = 0;
        @(negedge clk);
        start = 1'b0;
        while (sb.size() != 0 && cyc < W + 4) begin
            @(negedge clk);
            cyc++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'(acc_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
